// File: rtl/i2s_sample_tx.sv
// I2S (Philips) transmitter: converts the reverberator_core fixed-point output to WIDTH-bit samples
// and sends them mono on both channels. Define I2S_TX_SATURATE_EN to clip instead of wrapping.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif

module i2s_sample_tx #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned FRAC_BITS = `FIXED_POINT,
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned BCLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sample_clk,
  input  logic                enable,
  input  logic [IN_WIDTH-1:0] in,
  input  logic [2:0]          out_shift,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                overrun,
  output logic                underrun
);

  localparam int unsigned TW     = IN_WIDTH + 7;
  localparam int unsigned DIV_W  = $clog2(BCLK_DIV);
  localparam int unsigned SLOT_W = 6;
  localparam int unsigned POS_W  = 5;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  sc_prev_q, sc_prev_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic [WIDTH-1:0]      hold_q, hold_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic                  fresh_q, fresh_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;

  logic signed [TW-1:0]  in_ext, s_full, t_full;
  logic [WIDTH-1:0]      conv_w;

  // Fraction removal and gain at full width so no bits are lost before the reduction.
  always_comb begin
    in_ext = {{7{in[IN_WIDTH-1]}}, in};
    s_full = in_ext >>> FRAC_BITS;
    t_full = s_full <<< out_shift;
  end

`ifdef I2S_TX_SATURATE_EN
  localparam logic signed [TW-1:0] SAT_MAX = TW'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [TW-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    conv_w = t_full[WIDTH-1:0];
    if (t_full > SAT_MAX) begin
      conv_w = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (t_full < SAT_MIN) begin
      conv_w = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  logic unused_hi;

  always_comb begin
    conv_w    = t_full[WIDTH-1:0];
    unused_hi = ^t_full[TW-1:WIDTH];
  end
`endif

  logic              capture, div_wrap, bclk_fall, frame_start;
  logic [SLOT_W-1:0] slot_nxt;
  logic [POS_W-1:0]  bit_pos;
  logic [WIDTH-1:0]  tx_word;

  always_comb begin
    sync1_d    = sample_clk;
    sync2_d    = sync1_q;
    sc_prev_d  = sync2_q;
    div_d      = div_q;
    bclk_d     = bclk_q;
    slot_d     = slot_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    fresh_d    = fresh_q;
    overrun_d  = overrun_q;
    underrun_d = 1'b0;
    tx_word    = shift_q;

    capture     = sync2_q & ~sc_prev_q;
    div_wrap    = (div_q == DIV_W'(BCLK_DIV - 1));
    bclk_fall   = div_wrap & bclk_q;
    frame_start = bclk_fall & (slot_q == SLOT_W'(63));
    slot_nxt    = slot_q + SLOT_W'(1);
    bit_pos     = slot_nxt[POS_W-1:0];

    div_d = div_wrap ? '0 : div_q + DIV_W'(1);
    if (div_wrap) begin
      bclk_d = ~bclk_q;
    end

    if (capture) begin
      hold_d  = conv_w;
      fresh_d = 1'b1;
      if (fresh_q) begin
        overrun_d = 1'b1;
      end
    end

    // Slot, word select and data all move on the bclk falling edge.
    if (bclk_fall) begin
      slot_d  = slot_nxt;
      lrclk_d = (slot_nxt >= SLOT_W'(31)) && (slot_nxt <= SLOT_W'(62));
      if (frame_start) begin
        tx_word    = enable ? (capture ? conv_w : hold_q) : '0;
        shift_d    = tx_word;
        fresh_d    = 1'b0;
        underrun_d = ~fresh_q & ~capture;
      end
      sdata_d = |(tx_word & (MSB_MASK >> bit_pos));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sc_prev_q  <= 1'b0;
      div_q      <= '0;
      bclk_q     <= 1'b0;
      slot_q     <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      hold_q     <= '0;
      shift_q    <= '0;
      fresh_q    <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sc_prev_q  <= sc_prev_d;
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      slot_q     <= slot_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      fresh_q    <= fresh_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign bclk     = bclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Scoreboard bench for i2s_sample_tx: expected frame words are queued as samples are driven and
// checked against the decoded I2S stream.
`timescale 1ns/1ps
module tb_i2s_sample_tx;

  localparam int unsigned W = 24;
  localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sample_clk = 1'b0;
  logic        enable = 1'b1;
  logic [31:0] in_data = '0;
  logic [2:0]  out_shift = '0;
  logic        bclk, lrclk, sdata, overrun, underrun;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] hold_model = '0;
  int           mon_rises, mon_slot, u_cnt;
  int           frames_done = 0;
  logic         mon_prev;
  logic [63:0]  frame_bits, lr_bits;

  i2s_sample_tx #(.IN_WIDTH(32), .FRAC_BITS(8), .WIDTH(24), .BCLK_DIV(2)) dut (
    .clk(clk), .rstn(rstn), .sample_clk(sample_clk), .enable(enable), .in(in_data),
    .out_shift(out_shift), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] conv_model(input logic [31:0] x, input int sh);
    longint s, t;
    s = longint'($signed(x)) >>> 8;
    t = s <<< sh;
`ifdef I2S_TX_SATURATE_EN
    if (t > 64'sd8388607) return 24'h7FFFFF;
    if (t < -64'sd8388608) return 24'h800000;
`endif
    return t[W-1:0];
  endfunction

  // Decode the stream on bclk rises, one slot per rise, counted from reset release.
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      mon_rises = 0;
      mon_slot  = -1;
      u_cnt     = 0;
      mon_prev  = 1'b0;
    end else begin
      if (underrun) u_cnt++;
      if (bclk && !mon_prev) begin
        mon_slot = mon_rises % 64;
        frame_bits[63-mon_slot] = sdata;
        lr_bits[63-mon_slot]    = lrclk;
        mon_rises++;
        if (mon_slot == 63) begin
          logic [W-1:0] w;
          logic [63:0]  exp_frame;
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty frame=%0d got=%h exp=queued_word", frames_done, frame_bits);
          end else begin
            w = sb.pop_front();
            exp_frame = {w, 8'h00, w, 8'h00};
            if (frame_bits !== exp_frame) begin
              failures++;
              $display("FAIL frame_data frame=%0d got=%h exp=%h", frames_done, frame_bits, exp_frame);
            end
          end
          checks++;
          if (lr_bits !== LR_EXP) begin
            failures++;
            $display("FAIL frame_lrclk frame=%0d got=%h exp=%h", frames_done, lr_bits, LR_EXP);
          end
          frames_done++;
        end
      end
      mon_prev = bclk;
    end
  end

  task automatic wait_slot(input int n);
    int  seen;
    bit  hit;
    seen = mon_rises;
    hit  = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge clk); #1;
      if (mon_rises != seen) begin
        seen = mon_rises;
        if (mon_slot == n) hit = 1'b1;
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_slot_timeout got=none exp=slot%0d", n);
    end
  endtask

  task automatic send_sample(input logic [31:0] x, input logic [2:0] sh);
    in_data    = x;
    out_shift  = sh;
    sample_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1 sample_clk = 1'b0;
    hold_model = conv_model(x, int'(sh));
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bclk, lrclk, sdata, overrun, underrun} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", {bclk, lrclk, sdata, overrun, underrun});
    end
    @(negedge clk) rstn = 1'b1;
    sb.push_back('0);
    wait_slot(40);
    checks++;
    if (lrclk !== 1'b1) begin
      failures++;
      $display("FAIL lrclk_slot40 got=%b exp=1", lrclk);
    end
    #3 rstn = 1'b0;
    #1;
    checks++;
    if ({bclk, lrclk, sdata, overrun, underrun} !== 5'b0) begin
      failures++;
      $display("FAIL midframe_reset got=%b exp=00000", {bclk, lrclk, sdata, overrun, underrun});
    end
    @(negedge clk) rstn = 1'b1;
    sb.delete();
    sb.push_back('0);
    @(posedge clk); #1;
    checks++;
    if (bclk !== 1'b0) begin
      failures++;
      $display("FAIL bclk_after_1clk got=%b exp=0", bclk);
    end
    @(posedge clk); #1;
    checks++;
    if (bclk !== 1'b1) begin
      failures++;
      $display("FAIL bclk_after_2clk got=%b exp=1", bclk);
    end
  endtask

  // Consecutive frames each carrying a new sample.
  task automatic test_back_to_back;
    logic [31:0]  t_in[8];
    logic [2:0]   t_sh[8];
    logic [W-1:0] t_exp[8];
    t_in[0] = 32'h0040_0000; t_sh[0] = 3'd0; t_exp[0] = 24'h004000;
    t_in[1] = 32'h0040_0000; t_sh[1] = 3'd7; t_exp[1] = 24'h200000;
    t_in[2] = 32'hFFFF_FF00; t_sh[2] = 3'd0; t_exp[2] = 24'hFFFFFF;
`ifdef I2S_TX_SATURATE_EN
    t_in[3] = 32'h0100_0000; t_sh[3] = 3'd7; t_exp[3] = 24'h7FFFFF;
`else
    t_in[3] = 32'h0100_0000; t_sh[3] = 3'd7; t_exp[3] = 24'h800000;
`endif
    t_in[4] = 32'hFF00_0000; t_sh[4] = 3'd7; t_exp[4] = 24'h800000;
    for (int i = 5; i < 8; i++) begin
      t_in[i]  = $urandom();
      t_sh[i]  = 3'($urandom_range(0, 7));
      t_exp[i] = conv_model(t_in[i], int'(t_sh[i]));
    end
    for (int i = 0; i < 8; i++) begin
      wait_slot(8);
      send_sample(t_in[i], t_sh[i]);
      sb.push_back(t_exp[i]);
    end
    checks++;
    if (u_cnt !== 0) begin
      failures++;
      $display("FAIL no_underrun_b2b got=%0d exp=0", u_cnt);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL no_overrun_b2b got=%b exp=0", overrun);
    end
  endtask

  task automatic test_underrun;
    int u0;
    wait_slot(8);
    u0 = u_cnt;
    sb.push_back(hold_model);
    wait_slot(8);
    sb.push_back(hold_model);
    wait_slot(8);
    checks++;
    if (u_cnt - u0 !== 2) begin
      failures++;
      $display("FAIL underrun_pulses got=%0d exp=2", u_cnt - u0);
    end
    sb.push_back(hold_model);
  endtask

  task automatic test_overrun;
    wait_slot(8);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_before got=%b exp=0", overrun);
    end
    send_sample(32'h0012_3400, 3'd0);
    wait_slot(30);
    send_sample(32'h00AB_CD00, 3'd1);
    sb.push_back(hold_model);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%b exp=1", overrun);
    end
  endtask

  task automatic test_mute;
    int u0;
    wait_slot(8);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got=%b exp=1", overrun);
    end
    send_sample(32'h0055_5500, 3'd0);
    sb.push_back(hold_model);
    wait_slot(8);
    enable = 1'b0;
    send_sample(32'hFFF0_0000, 3'd2);
    sb.push_back('0);
    wait_slot(8);
    enable = 1'b1;
    u0 = u_cnt;
    sb.push_back(hold_model);
    wait_slot(8);
    checks++;
    if (u_cnt - u0 !== 1) begin
      failures++;
      $display("FAIL underrun_after_mute got=%0d exp=1", u_cnt - u0);
    end
    wait_slot(2);
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL sb_drained got=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_underrun();
    test_overrun();
    test_mute();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
